regfile_dump_reader: RTL and testbench

- Read-side debug block for the single-cycle CPU.
- On a start pulse it walks the architectural register file through a dedicated read port, one register at a time.
- Each 32-bit value is serialized as little-endian bytes onto a valid/ready byte stream for the debug link.
- It sits beside the register file and never writes CPU state.

---
 rtl/regfile_dump_reader.sv | 162 ++++++++++++++++
 tb/tb_regfile_dump_reader.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: debug-side walker that reads the architectural register
// file one entry at a time and streams each value as little-endian bytes over a
// valid/ready byte interface. It only reads CPU state.
// Optional build macro REGDUMP_PC_EN appends the current PC as one extra word
// after the last register.
module regfile_dump_reader #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] rf_raddr,
    input  logic [DW-1:0] rf_rdata,
    input  logic [DW-1:0] pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    out_data
);

    localparam int NBYTES = DW / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [AW-1:0]    r_idx;
    logic [BCW-1:0]   r_byte_cnt;
    logic [DW-1:0]    r_shift;
    logic             w_xfer;
    logic             w_last_byte;
    logic             w_last_reg;
    logic             w_pc_phase;
    logic [DW-1:0]    w_fetch_data;

`ifdef REGDUMP_PC_EN
    // Marks that the register walk is finished and the PC word is in flight.
    logic r_pc_phase;

    assign w_pc_phase   = r_pc_phase;
    assign w_fetch_data = r_pc_phase ? pc : rf_rdata;

    // Enter the PC phase after the last register's final byte; leave it at DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_phase <= 1'b0;
        end else if (r_state == DONE) begin
            r_pc_phase <= 1'b0;
        end else if (r_state == SEND && w_xfer && w_last_byte && w_last_reg) begin
            r_pc_phase <= 1'b1;
        end
    end
`else
    // The pc port is present for interface compatibility but carries no function here.
    logic w_pc_unused;

    assign w_pc_unused  = ^pc;
    assign w_pc_phase   = 1'b0;
    assign w_fetch_data = rf_rdata;
`endif

    assign w_xfer      = out_valid && out_ready;
    assign w_last_byte = (r_byte_cnt == BCW'(NBYTES - 1));
    assign w_last_reg  = (r_idx == AW'(NREGS - 1));

    // Read address comes straight from the registered index, so it never glitches.
    assign rf_raddr  = r_idx;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign out_valid = (r_state == SEND);
    assign out_data  = (r_state == SEND) ? r_shift[7:0] : 8'h00;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start is only looked at in IDLE, so it cannot queue a restart.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = FETCH;
                end
            end
            FETCH: begin
                w_state_nxt = SEND;
            end
            SEND: begin
                if (w_xfer && w_last_byte) begin
                    if (!w_last_reg) begin
                        w_state_nxt = FETCH;
                    end else begin
`ifdef REGDUMP_PC_EN
                        w_state_nxt = w_pc_phase ? DONE : FETCH;
`else
                        w_state_nxt = DONE;
`endif
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: capture a word in FETCH, shift it out a byte per transfer in SEND.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx      <= '0;
            r_byte_cnt <= '0;
            r_shift    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx <= '0;
                    end
                end
                FETCH: begin
                    r_shift    <= w_fetch_data;
                    r_byte_cnt <= '0;
                end
                SEND: begin
                    if (w_xfer) begin
                        r_shift    <= r_shift >> 8;
                        r_byte_cnt <= r_byte_cnt + BCW'(1);
                        // During the PC phase the index stays parked on the last register.
                        if (w_last_byte && !w_last_reg && !w_pc_phase) begin
                            r_idx <= r_idx + AW'(1);
                        end
                    end
                end
                DONE: begin
                    r_idx <= '0;
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Self-checking bench for regfile_dump_reader with randomized register contents
// and randomized sink backpressure, checked against a byte-stream model.
module tb_regfile_dump_reader;

    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NB    = DW / 8;
`ifdef REGDUMP_PC_EN
    localparam int PC_EN = 1;
`else
    localparam int PC_EN = 0;
`endif
    localparam int DUMP_CYC = NREGS * (1 + NB) + PC_EN * (1 + NB);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic [DW-1:0] pc;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_data;

    logic [DW-1:0] regs     [NREGS];
    logic [DW-1:0] exp_vals [NREGS];
    logic [7:0]    got [$];
    logic [7:0]    exp [$];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int done_cnt, done_cyc, first_vld_cyc, stab_err, s_cyc;
    logic       hold_pend;
    logic [7:0] hold_data;

    regfile_dump_reader #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rf_raddr  (rf_raddr),
        .rf_rdata  (rf_rdata),
        .pc        (pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    assign rf_rdata = regs[rf_raddr];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the stream on the falling edge: collect bytes, note done, watch hold stability.
    always @(negedge clk) begin
        if (hold_pend && (!out_valid || out_data !== hold_data)) stab_err++;
        hold_pend = out_valid && !out_ready;
        hold_data = out_data;
        if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
        if (out_valid && out_ready) got.push_back(out_data);
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_mon();
        got.delete();
        done_cnt      = 0;
        done_cyc      = -1;
        first_vld_cyc = -1;
        stab_err      = 0;
        hold_pend     = 1'b0;
    endtask

    // Expected stream: each register LSB first in index order, then PC if enabled.
    task automatic mk_exp();
        exp.delete();
        for (int i = 0; i < NREGS; i++)
            for (int b = 0; b < NB; b++) exp.push_back(8'(exp_vals[i] >> (8 * b)));
        if (PC_EN != 0)
            for (int b = 0; b < NB; b++) exp.push_back(8'(pc >> (8 * b)));
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input bit rnd, output bit tmo);
        int n = 0;
        tmo = 1'b0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #1;
            out_ready = rnd ? ($urandom_range(0, 3) == 0) : 1'b1;
            n++;
        end
        if (done_cnt == 0) tmo = 1'b1;
    endtask

    task automatic test_reset();
        bit tmo;
        for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
        out_ready = 1'b1;
        clear_mon();
        pulse_start();
        repeat (15) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_async_valid: got %b want 0", out_valid);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        clear_mon();
        #1;
        n_chk++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_chk++; if (done !== 1'b0)  begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        n_chk++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", out_data); end
        n_chk++; if (rf_raddr !== '0) begin n_fail++; $display("FAIL rst_raddr: got %0d want 0", rf_raddr); end
        run_until_done(20, 1'b0, tmo);
        n_chk++;
        if (got.size() != 0 || done_cnt != 0 || first_vld_cyc != -1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_quiet: bytes %0d done %0d busy %b want 0 0 0", got.size(), done_cnt, busy);
        end
    endtask

    task automatic test_full_dump();
        bit tmo;
        int bad;
        for (int i = 0; i < NREGS; i++) begin
            regs[i]     = 32'h11223300 + i;
            exp_vals[i] = 32'h11223300 + i;
        end
        pc = 32'h80000010;
        mk_exp();
        clear_mon();
        out_ready = 1'b1;
        pulse_start();
        run_until_done(DUMP_CYC + 20, 1'b0, tmo);
        n_chk++; if (tmo) begin n_fail++; $display("FAIL full_timeout: no done within budget"); end
        n_chk++;
        if (first_vld_cyc != s_cyc + 2) begin
            n_fail++; $display("FAIL full_first_valid: got cycle %0d want %0d", first_vld_cyc, s_cyc + 2);
        end
        n_chk++;
        if (got.size() < 4 || got[0] !== 8'h00 || got[1] !== 8'h33 || got[2] !== 8'h22 || got[3] !== 8'h11) begin
            n_fail++; $display("FAIL full_x0_bytes: first bytes wrong, want 00 33 22 11");
        end
        n_chk++;
        if (got.size() != exp.size()) begin
            n_fail++; $display("FAIL full_count: got %0d want %0d", got.size(), exp.size());
        end
        bad = -1;
        for (int i = 0; i < got.size() && i < exp.size(); i++) if (got[i] !== exp[i] && bad < 0) bad = i;
        n_chk++;
        if (bad >= 0) begin
            n_fail++; $display("FAIL full_bytes[%0d]: got %h want %h", bad, got[bad], exp[bad]);
        end
        n_chk++;
        if (done_cyc != s_cyc + 1 + DUMP_CYC) begin
            n_fail++; $display("FAIL full_done_cycle: got %0d want %0d", done_cyc, s_cyc + 1 + DUMP_CYC);
        end
        n_chk++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL full_after_done: busy %b done %b want 0 0", busy, done);
        end
`ifdef REGDUMP_PC_EN
        n_chk++;
        if (got.size() != 132 || got[128] !== 8'h10 || got[129] !== 8'h00 || got[130] !== 8'h00 || got[131] !== 8'h80) begin
            n_fail++; $display("FAIL pc_tail: count %0d want 132 ending 10 00 00 80", got.size());
        end
`endif
    endtask

    task automatic test_backpressure();
        bit tmo;
        int bad;
        for (int i = 0; i < NREGS; i++) begin
            regs[i]     = $urandom;
            exp_vals[i] = regs[i];
        end
        pc = $urandom;
        mk_exp();
        clear_mon();
        pulse_start();
        run_until_done(4000, 1'b1, tmo);
        n_chk++; if (tmo) begin n_fail++; $display("FAIL bp_timeout: no done within budget"); end
        n_chk++;
        if (got.size() != exp.size()) begin
            n_fail++; $display("FAIL bp_count: got %0d want %0d", got.size(), exp.size());
        end
        bad = -1;
        for (int i = 0; i < got.size() && i < exp.size(); i++) if (got[i] !== exp[i] && bad < 0) bad = i;
        n_chk++;
        if (bad >= 0) begin
            n_fail++; $display("FAIL bp_bytes[%0d]: got %h want %h", bad, got[bad], exp[bad]);
        end
        n_chk++;
        if (stab_err != 0) begin
            n_fail++; $display("FAIL bp_hold_stable: %0d unstable stall cycles, want 0", stab_err);
        end
        n_chk++;
        if (done_cnt != 1) begin
            n_fail++; $display("FAIL bp_done_count: got %0d want 1", done_cnt);
        end
    endtask

    task automatic test_start_while_busy();
        int n = 0;
        int bad;
        bit pulsed = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            regs[i]     = $urandom;
            exp_vals[i] = regs[i];
        end
        mk_exp();
        clear_mon();
        pulse_start();
        while (done_cnt == 0 && n < 4000) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 1) == 0);
            start = (!pulsed && got.size() == 9);
            if (start) pulsed = 1'b1;
            n++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        n_chk++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL swb_single_done: done %0d busy %b want 1 0", done_cnt, busy);
        end
        n_chk++;
        if (got.size() != exp.size()) begin
            n_fail++; $display("FAIL swb_count: got %0d want %0d", got.size(), exp.size());
        end
        bad = -1;
        for (int i = 0; i < got.size() && i < exp.size(); i++) if (got[i] !== exp[i] && bad < 0) bad = i;
        n_chk++;
        if (bad >= 0) begin
            n_fail++; $display("FAIL swb_bytes[%0d]: got %h want %h", bad, got[bad], exp[bad]);
        end
    endtask

    task automatic test_mid_change();
        int n = 0;
        int bad;
        bit wrote = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            regs[i]     = $urandom;
            exp_vals[i] = regs[i];
        end
        regs[5]     = '0;
        exp_vals[5] = 32'hDEADBEEF;
        mk_exp();
        clear_mon();
        pulse_start();
        while (done_cnt == 0 && n < 4000) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 1) == 0);
            if (!wrote && got.size() == 17) begin
                regs[5] = 32'hDEADBEEF;
                regs[3] = ~exp_vals[3];
                wrote   = 1'b1;
            end
            n++;
        end
        n_chk++;
        if (got.size() != exp.size()) begin
            n_fail++; $display("FAIL mid_count: got %0d want %0d", got.size(), exp.size());
        end
        n_chk++;
        if (got.size() < 24 || {got[23], got[22], got[21], got[20]} !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL mid_x5: x5 bytes not DEADBEEF");
        end
        n_chk++;
        if (got.size() < 16 || {got[15], got[14], got[13], got[12]} !== exp_vals[3]) begin
            n_fail++; $display("FAIL mid_x3: x3 bytes changed, want %h", exp_vals[3]);
        end
        bad = -1;
        for (int i = 0; i < got.size() && i < exp.size(); i++) if (got[i] !== exp[i] && bad < 0) bad = i;
        n_chk++;
        if (bad >= 0) begin
            n_fail++; $display("FAIL mid_bytes[%0d]: got %h want %h", bad, got[bad], exp[bad]);
        end
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        pc        = '0;
        for (int i = 0; i < NREGS; i++) regs[i] = '0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_full_dump();
        test_backpressure();
        test_start_while_busy();
        test_mid_change();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
